// File: rtl/nnoc_fetch.sv
// nnoc_fetch: instruction fetch stage of the nnoc RV32I core.
// Holds the PC, issues in-order word reads to instruction memory and buffers
// returned words with their PCs in a DEPTH-entry FIFO feeding decode.
// A redirect from execute flushes the FIFO and restarts fetch at a new PC.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf_stall and
// perf_bubble counters as extra output ports.
module nnoc_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_bubble
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     fifo_data [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];

  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic [CW-1:0]   out_after_rsp;
  logic [CW:0]     inflight;
  logic            credit_ok;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Handshake qualifiers, credit check and response PC reconstruction.
  always_comb begin
    rsp_take        = imem_rsp_valid && (outstanding != '0);
    out_after_rsp   = outstanding - CW'(rsp_take);
    inflight        = {1'b0, outstanding} + {1'b0, count};
    credit_ok       = inflight < (CW + 1)'(DEPTH);
    redirect_target = redirect_pc & ~XLEN'(3);
    // Requests are sequential from pc with no gaps while in RUN (a redirect
    // with requests in flight goes through DRAIN), so the oldest outstanding
    // request's address is pc minus four per outstanding request.
    rsp_pc          = pc - (XLEN'(outstanding) << 2);
  end

  // Request/instruction outputs and FIFO push/pop decisions.
  always_comb begin
    imem_req_valid = (state == RUN) && fetch_en && !redirect_valid && credit_ok;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    inst_valid     = (count != '0) && !redirect_valid;
    inst_data      = (count != '0) ? fifo_data[rd_ptr] : '0;
    inst_pc        = (count != '0) ? fifo_pc[rd_ptr]   : '0;
    push           = (state == RUN) && rsp_take && !redirect_valid;
    pop            = inst_valid && inst_ready;
  end

  // Next-state logic for the IDLE/RUN/DRAIN controller.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_en) state_nxt = RUN;
      RUN: begin
        if (redirect_valid && (out_after_rsp != '0))
          state_nxt = DRAIN;
        else if (!fetch_en && (out_after_rsp == '0))
          state_nxt = IDLE;
      end
      DRAIN:   if (out_after_rsp == '0) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // PC and outstanding-request counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
    end else begin
      if (redirect_valid)
        pc <= redirect_target;
      else if (req_fire)
        pc <= pc + XLEN'(4);
      outstanding <= out_after_rsp + CW'(req_fire);
    end
  end

  // FIFO pointers and occupancy; redirect clears everything in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only observed through the count gate.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters for decode back-pressure and fetch bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
    end else begin
      if (inst_valid && !inst_ready && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
      if ((state == RUN) && !inst_valid && (perf_bubble != '1))
        perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nnoc_fetch.sv
// Scoreboard bench for nnoc_fetch: directed scenarios push expected request
// addresses and expected {pc, word} pairs; monitors compare as the DUT issues
// requests and hands instructions to decode. A small memory model answers
// requests in order with a configurable latency.
module tb_nnoc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_bubble;
`endif

  nnoc_fetch #(.XLEN(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall     (perf_stall),
    .perf_bubble    (perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int acc_cnt = 0;
  logic [31:0] rsp_addr = '0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Request monitor: record accepted reads for the memory model, compare addresses.
  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      acc_cnt++;
      pend.push_back('{addr: imem_req_addr, due: cyc + lat});
      if (exp_addr.size() > 0) check("req_addr", imem_req_addr, exp_addr.pop_front());
    end
  end

  // Memory model: in-order responses, one per cycle, once latency has elapsed.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        rsp_addr       = pend[0].addr;
        imem_rsp_data  = word_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Decode-side monitor: every consumed instruction must match the scoreboard head.
  always @(negedge clk) begin
    logic [31:0] e;
    if (inst_valid && inst_ready) begin
      if (exp_pc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h with nothing expected", inst_pc);
      end else begin
        e = exp_pc.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_data", inst_data, word_of(e));
      end
    end
  end

  task automatic do_reset();
    reset          = 1'b0;
    fetch_en       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while (exp_pc.size() != 0 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_pc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d instructions missing after %0d cycles", name, exp_pc.size(), maxc);
      exp_pc.delete();
    end
    inst_ready = 1'b0;
    check({name, "_addr_left"}, exp_addr.size(), 32'd0);
    exp_addr.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    reset          = 1'b0;
    fetch_en       = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    // 1: reset values, idle, then straight-line fetch with 1-cycle memory.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_inst_valid", inst_valid, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_stall", perf_stall, 32'd0);
    check("rst_perf_bubble", perf_bubble, 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_req_valid", imem_req_valid, 32'd0);
    @(posedge clk);
    #1;
    exp_addr = '{32'h0, 32'h4, 32'h8};
    exp_pc   = '{32'h0, 32'h4, 32'h8};
    inst_ready = 1'b1;
    fetch_en   = 1'b1;
    wait_drain("t1", 40);

    // 2: decode back-pressure fills the FIFO, fetch stalls, then resumes.
    do_reset();
    lat  = 1;
    base = acc_cnt;
    exp_addr = '{32'h0, 32'h4};
    fetch_en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_accepted", acc_cnt - base, 32'd2);
    check("t2_req_valid", imem_req_valid, 32'd0);
    check("t2_inst_valid", inst_valid, 32'd1);
    check("t2_inst_pc", inst_pc, 32'h0);
    repeat (3) @(negedge clk);
    check("t2_inst_pc_held", inst_pc, 32'h0);
    check("t2_inst_data_held", inst_data, word_of(32'h0));
    @(posedge clk);
    #1;
    exp_addr.push_back(32'h8);
    exp_pc = '{32'h0, 32'h4, 32'h8};
    inst_ready = 1'b1;
    wait_drain("t2", 40);

    // 3: redirect with two reads in flight at latency 3 -> drain, restart at 0x100.
    do_reset();
    lat  = 3;
    base = acc_cnt;
    exp_addr = '{32'h0, 32'h4, 32'h100};
    fetch_en = 1'b1;
    n = 0;
    while ((acc_cnt - base) < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t3_two_accepted", acc_cnt - base, 32'd2);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    check("t3_redir_req_valid", imem_req_valid, 32'd0);
    check("t3_redir_inst_valid", inst_valid, 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    exp_pc = '{32'h100};
    inst_ready = 1'b1;
    @(negedge clk);
    check("t3_drain_req_valid", imem_req_valid, 32'd0);
    wait_drain("t3", 40);

    // 4: redirect lands in the same cycle as the response for 0x8.
    do_reset();
    lat = 1;
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'h40};
    exp_pc   = '{32'h0, 32'h4, 32'h40};
    inst_ready = 1'b1;
    fetch_en   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(imem_rsp_valid && rsp_addr == 32'h8) && n < 30);
    check("t4_rsp8_seen", {31'd0, imem_rsp_valid && rsp_addr == 32'h8}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    check("t4_redir_inst_valid", inst_valid, 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_drain("t4", 40);

    // 5: asynchronous reset with a full FIFO, then restart from RESET_PC.
    do_reset();
    lat = 1;
    fetch_en = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t5_full_inst_valid", inst_valid, 32'd1);
    check("t5_pre_req_addr", imem_req_addr, 32'h8);
    #2;
    reset    = 1'b0;
    fetch_en = 1'b0;
    #1;
    check("t5_async_req_valid", imem_req_valid, 32'd0);
    check("t5_async_inst_valid", inst_valid, 32'd0);
    check("t5_async_inst_data", inst_data, 32'd0);
    check("t5_async_inst_pc", inst_pc, 32'd0);
    check("t5_async_req_addr", imem_req_addr, 32'h0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    exp_addr = '{32'h0};
    exp_pc   = '{32'h0};
    inst_ready = 1'b1;
    fetch_en   = 1'b1;
    wait_drain("t5", 40);

    // 6: redirect to the top word, memory stalled; PC wraps to 0.
    do_reset();
    lat = 1;
    imem_req_ready = 1'b0;
    fetch_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t6_withdrawn", imem_req_valid, 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t6_req_valid", imem_req_valid, 32'd1);
    check("t6_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    exp_addr = '{32'hFFFF_FFFC, 32'h0};
    exp_pc   = '{32'hFFFF_FFFC, 32'h0};
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    wait_drain("t6", 40);

`ifdef FETCH_PERF_CNT_EN
    // 7: ten cycles of inst_valid with decode stalled.
    do_reset();
    lat = 1;
    fetch_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_valid && n < 20);
    check("t7_inst_valid", inst_valid, 32'd1);
    repeat (10) @(negedge clk);
    check("t7_perf_stall", perf_stall, 32'd10);
    @(posedge clk);
    #1;
`endif

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
